// File: rtl/windower_pkg.sv
// rtl/windower_pkg.sv - shared constants, FSM states and element packing for block_windower
package windower_pkg;
    localparam int BLK       = 8;
    localparam int BLK_ELEMS = BLK * BLK;

    typedef enum logic [1:0] {
        FILL,
        LOAD,
        PRESENT
    } win_state_t;

    // Bit offset of element (r, c) inside a packed 8x8 window of n-bit elements.
    function automatic int elem_off(input int r, input int c, input int n);
        return (r * BLK + c) * n;
    endfunction
endpackage

// File: rtl/strip_buffer.sv
// rtl/strip_buffer.sv - 8-row pixel strip store with an 8x8 column-block read port
module strip_buffer
    import windower_pkg::*;
#(
    parameter int N     = 16,
    parameter int IMG_W = 128,
    localparam int CW   = $clog2(IMG_W),
    localparam int BW   = $clog2(IMG_W / BLK)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [2:0]             wr_row,
    input  logic [CW-1:0]          wr_col,
    input  logic [N-1:0]           wr_data,
    input  logic [BW-1:0]          rd_blk,
    output logic [N*BLK_ELEMS-1:0] rd_data
);
    logic [N-1:0] mem [BLK][IMG_W];

    // Pixel write port; no reset needed since every strip is fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Element (r, c) of block blk is column blk*8 + c of row r; IMG_W is a multiple of 8,
    // so the column index is just {blk, c}.
    for (genvar r = 0; r < BLK; r++) begin : g_row
        for (genvar c = 0; c < BLK; c++) begin : g_col
            assign rd_data[elem_off(r, c, N) +: N] = mem[r][{rd_blk, 3'(c)}];
        end
    end
endmodule

// File: rtl/block_windower.sv
// rtl/block_windower.sv - raster pixel stream to 8x8 window stream, one strip at a time
module block_windower
    import windower_pkg::*;
#(
    parameter int N     = 16,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_pixel,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [N*64-1:0]            win_data,
    output logic [$clog2(IMG_H/8)-1:0] win_row,
    output logic [$clog2(IMG_W/8)-1:0] win_col,
    output logic                       win_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int SW = $clog2(IMG_H / BLK);
    localparam int BW = $clog2(IMG_W / BLK);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [SW-1:0] STRIP_LAST = SW'(IMG_H / BLK - 1);
    localparam logic [BW-1:0] BLK_LAST   = BW'(IMG_W / BLK - 1);

    win_state_t             state_q,     state_d;
    logic [CW-1:0]          col_q,       col_d;
    logic [2:0]             row_q,       row_d;
    logic [SW-1:0]          strip_q,     strip_d;
    logic [BW-1:0]          blk_q,       blk_d;
    logic                   win_valid_q, win_valid_d;
    logic [N*BLK_ELEMS-1:0] win_data_q,  win_data_d;
    logic [SW-1:0]          win_row_q,   win_row_d;
    logic [BW-1:0]          win_col_q,   win_col_d;
    logic                   win_last_q,  win_last_d;

    logic                   wr_en;
    logic [N-1:0]           wr_data;
    logic [N*BLK_ELEMS-1:0] rd_data;

    // Input is only open while filling, so the buffer is never read and written together.
    assign in_ready = (state_q == FILL);
    assign wr_en    = in_ready && in_valid;
    assign wr_data  = in_pixel - N'(SHIFT);

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_last  = win_last_q;

    strip_buffer #(
        .N     (N),
        .IMG_W (IMG_W)
    ) u_strip_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_row  (row_q),
        .wr_col  (col_q),
        .wr_data (wr_data),
        .rd_blk  (blk_q),
        .rd_data (rd_data)
    );

    // Next-state logic: fill a strip, then alternate LOAD/PRESENT once per block.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        strip_d     = strip_q;
        blk_d       = blk_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_last_d  = win_last_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == 3'd7) begin
                            row_d   = '0;
                            blk_d   = '0;
                            state_d = LOAD;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                win_data_d  = rd_data;
                win_row_d   = strip_q;
                win_col_d   = blk_q;
                win_last_d  = (strip_q == STRIP_LAST) && (blk_q == BLK_LAST);
                win_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (win_ready) begin
                    win_valid_d = 1'b0;
                    if (blk_q != BLK_LAST) begin
                        blk_d   = blk_q + 1'b1;
                        state_d = LOAD;
                    end else begin
                        strip_d = (strip_q == STRIP_LAST) ? '0 : strip_q + 1'b1;
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and output registers; reset drops any partial strip and clears the window outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            strip_q     <= '0;
            blk_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            strip_q     <= strip_d;
            blk_q       <= blk_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_last_q  <= win_last_d;
        end
    end
endmodule

// File: doc/block_windower.md
Name: block_windower

Overview:
- Upstream stage of dct2d: accepts a raster-order pixel stream (IMG_W x IMG_H, one pixel per beat) and emits 8x8 windows packed on the flat N*64 bus that dct2d takes on data_in.
- Buffers one 8-row strip, then drains it as IMG_W/8 windows left to right, strip by strip, until the frame ends.
- Valid/ready on both sides, so the DCT side can stall the source.

Parameters:
- N, 16, pixel/window-element width in bits (matches dct2d N).
- IMG_W, 128, image width in pixels; multiple of 8.
- IMG_H, 128, image height in pixels; multiple of 8.
- SHIFT, 0, level shift subtracted from every pixel before storage (128 for JPEG-style centring).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  block accepts a pixel this cycle.
- in_pixel  in  N  raster-order pixel, signed.
- win_valid  out  1  win_data holds a complete window.
- win_ready  in  1  consumer takes the window.
- win_data  out  N*64  window; element (r,c) at bits [(r*8+c)*N +: N].
- win_row  out  $clog2(IMG_H/8)  strip index of the current window.
- win_col  out  $clog2(IMG_W/8)  block index within the strip.
- win_last  out  1  current window is the final window of the frame.

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=FILL, col/row/strip/blk counters=0, win_valid=0, win_data=0, win_row=0, win_col=0, win_last=0. in_ready=1 while in FILL, including during reset; beats presented while rst_n is low are ignored.
- States: FILL, LOAD, PRESENT.
- FILL:
  - in_ready=1, win_valid=0.
  - A beat is accepted on in_valid&&in_ready. It stores (in_pixel - SHIFT), truncated to N bits (two's-complement wrap), at buf[row][col].
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - Accepting pixel (row 7, col IMG_W-1) sets row=0, blk=0 and moves to LOAD.
- LOAD:
  - in_ready=0; one cycle.
  - Registers win_data from buf[0..7][blk*8 .. blk*8+7], and registers win_row=strip, win_col=blk, win_last=(strip==IMG_H/8-1 && blk==IMG_W/8-1).
  - Next state PRESENT with win_valid=1.
- PRESENT:
  - in_ready=0. win_valid, win_data, win_row, win_col and win_last are held stable until win_valid&&win_ready.
  - On handshake, win_valid drops the next cycle.
  - If blk < IMG_W/8-1: blk++ and go to LOAD.
  - Otherwise go to FILL. strip increments, wrapping to 0 after IMG_H/8-1, which starts the next frame with no gap.
- Latency and throughput:
  - Last pixel of a strip accepted at cycle t gives win_valid=1 at t+2.
  - With win_ready held high, one window every 2 cycles.
  - Input is stalled for 2*IMG_W/8 cycles per strip.
- Boundaries:
  - No simultaneous read/write of buf: input is blocked outside FILL.
  - in_valid held high during drain loses no pixel.
  - win_ready asserted while win_valid=0 has no effect.
  - Reset asserted mid-strip or mid-drain discards the partial strip and returns all outputs to reset values immediately (asynchronous).
- Arithmetic: no saturation; only the SHIFT subtraction, wrapped to N bits.

Decomposition:
- Package windower_pkg: BLK=8, BLK_ELEMS=64, state enum {FILL, LOAD, PRESENT}, element-offset function (r*8+c)*N.
- Sub-module strip_buffer: 8 x IMG_W x N storage with one pixel write port (row, col) and one 8x8 column-block read port (blk) returning N*64 bits.

Test Plan:
1. Reset: assert rst_n=0 mid-FILL with in_valid=1 -> in_ready=1, win_valid=0, win_data=0, all counters 0; after release, first accepted pixel lands at (0,0).
2. Ramp image, pixel=(r*128+c) mod 2^16, SHIFT=0, win_ready=1:
   - Window (0,0): element 9 = 129, element 63 = 903.
   - Window (0,15): element 0 = 120.
   - win_valid rises exactly 2 cycles after pixel (7,127) is accepted.
3. Backpressure: win_ready=0 for 5 cycles on window (2,3) -> win_data, win_row=2, win_col=3 stable; no advance; next window (2,4) follows 2 cycles after the handshake.
4. Input stall: in_valid held high continuously -> in_ready=0 for 32 cycles per strip; all 16384 pixels appear exactly once across 256 windows (scoreboard).
5. Frame wrap: stream 2 frames -> win_last=1 only on window (15,15); the next window is (0,0) of frame 2 with correct data.
6. SHIFT=128: pixel 0 -> element 0xFF80 (-128); pixel 255 -> 127.
